// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv core slice: timer register offsets,
// data-memory op encoding and the timer interrupt request states.
package riscv_pkg;

    // Word offsets inside the timer window (addr[3:2])
    localparam logic [1:0] TIMER_MTIME_LO    = 2'd0;
    localparam logic [1:0] TIMER_MTIME_HI    = 2'd1;
    localparam logic [1:0] TIMER_MTIMECMP_LO = 2'd2;
    localparam logic [1:0] TIMER_MTIMECMP_HI = 2'd3;

    // dmem_op encoding, shared with riscv_control
    localparam int unsigned DMEM_OP_STORE_BIT = 2;
    localparam logic [1:0]  DMEM_SIZE_WORD    = 2'd3;

    // Interrupt request life cycle
    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SPENT
    } timer_irq_state_t;

endpackage

// File: rtl/riscv_timer_prescaler.sv
// Divides the core clock down to the mtime increment rate.
// tick is high for one cycle every PRESCALE cycles (every cycle when
// PRESCALE = 1); clear restarts the count from zero.
module riscv_timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] count;

    assign tick = (count == LAST);

    // Count 0..PRESCALE-1, restart on wrap or on an explicit clear
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/riscv_timer.sv
// Machine timer: 64-bit mtime/mtimecmp mapped at BASE_ADDR..BASE_ADDR+0xC,
// raising timer_irq when mtime >= mtimecmp and holding it until the control
// stage samples it (imem_data_ready high).
// Optional build macro RISCV_TIMER_SNAPSHOT_EN: a load of mtime_lo latches
// the upper half into a shadow that a later mtime_hi load returns.
module riscv_timer
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hC000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_en,
    input  logic [2:0]  dmem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic        imem_data_ready,
    output logic        timer_irq,
    output logic [63:0] mtime
);

    logic [63:0]      mtimecmp;
    logic             tick;
    logic             window;
    logic             hit;
    logic             is_store;
    logic [1:0]       sel;
    logic             wr_mtime_lo;
    logic             wr_mtime_hi;
    logic             wr_cmp_lo;
    logic             wr_cmp_hi;
    logic             cmp_write;
    logic             match;
    logic [31:0]      rd_mux;
    timer_irq_state_t state;
    logic             rearmed;

    assign window   = dmem_en && (addr[31:4] == BASE_ADDR[31:4]);
    assign hit      = window && (addr[1:0] == 2'b00) && (dmem_op[1:0] == DMEM_SIZE_WORD);
    assign is_store = dmem_op[DMEM_OP_STORE_BIT];
    assign sel      = addr[3:2];

    assign wr_mtime_lo = hit && is_store && (sel == TIMER_MTIME_LO);
    assign wr_mtime_hi = hit && is_store && (sel == TIMER_MTIME_HI);
    assign wr_cmp_lo   = hit && is_store && (sel == TIMER_MTIMECMP_LO);
    assign wr_cmp_hi   = hit && is_store && (sel == TIMER_MTIMECMP_HI);
    assign cmp_write   = wr_cmp_lo || wr_cmp_hi;

    assign match = (mtime >= mtimecmp);

    riscv_timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(wr_mtime_lo || wr_mtime_hi),
        .tick (tick)
    );

`ifdef RISCV_TIMER_SNAPSHOT_EN
    logic [31:0] mtime_hi_shadow;

    // Capture the upper half whenever the lower half is read
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_hi_shadow <= '0;
        end else if (hit && !is_store && (sel == TIMER_MTIME_LO)) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end
`endif

    // Select the register addressed by a load
    always_comb begin
        rd_mux = '0;
        case (sel)
            TIMER_MTIME_LO:    rd_mux = mtime[31:0];
`ifdef RISCV_TIMER_SNAPSHOT_EN
            TIMER_MTIME_HI:    rd_mux = mtime_hi_shadow;
`else
            TIMER_MTIME_HI:    rd_mux = mtime[63:32];
`endif
            TIMER_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
            TIMER_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
            default:           rd_mux = '0;
        endcase
    end

    // mtime: a store to either half suppresses that cycle's increment
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= wdata;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp halves written independently
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= '1;
        end else if (wr_cmp_lo) begin
            mtimecmp[31:0] <= wdata;
        end else if (wr_cmp_hi) begin
            mtimecmp[63:32] <= wdata;
        end
    end

    // Load response: any load inside the window answers, illegal ones with 0
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else if (window && !is_store) begin
            rdata       <= hit ? rd_mux : '0;
            rdata_valid <= 1'b1;
        end else begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end
    end

    // Request FSM; rearmed records an mtimecmp write seen while PEND, so the
    // request returns to IDLE instead of SPENT once it has been taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rearmed   <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cmp_write && match) begin
                        state     <= PEND;
                        timer_irq <= 1'b1;
                    end
                end
                PEND: begin
                    if (timer_irq && imem_data_ready) begin
                        timer_irq <= 1'b0;
                        rearmed   <= 1'b0;
                        state     <= (rearmed || cmp_write) ? IDLE : SPENT;
                    end else if (cmp_write) begin
                        rearmed <= 1'b1;
                    end
                end
                SPENT: begin
                    if (cmp_write) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rearmed   <= 1'b0;
                    timer_irq <= 1'b0;
                end
            endcase
        end
    end

endmodule
